// File: rtl/key_expansion_seq_if.sv
// Key-schedule bus: key load request, status flags and the round-key read port.
// The master side loads keys and reads round keys; the slave side is the scheduler.
interface key_expansion_seq_if #(
  parameter int MAX_NK = 8
);
  logic [0:32*MAX_NK-1] key;
  logic [1:0]           key_size;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 key_valid;
  logic [3:0]           nr;
  logic [3:0]           rd_round;
  logic [127:0]         rd_key;

  modport master (
    output key, key_size, start, rd_round,
    input  busy, done, err, key_valid, nr, rd_key
  );

  modport slave (
    input  key, key_size, start, rd_round,
    output busy, done, err, key_valid, nr, rd_key
  );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock through a single
// shared SubWord unit, with a combinational round-key read port over the word store.
module key_expansion_seq #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_expansion_seq_if.slave    bus
);
  localparam int         NWORDS   = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // S-box computed as affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int n = 1; n < 8; n++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]  rst_sync_q;
  logic        rst_int_n;

  state_t      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic [3:0]  nk_q, nk_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [5:0]  last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        kv_q, kv_d;
  logic [3:0]  nr_q, nr_d;

  logic [31:0] w_q [NWORDS];

  logic [3:0]  req_nk;
  logic [3:0]  req_nr;
  logic        req_legal;
  logic        load_en;
  logic        wr_en;
  logic [31:0] prev_w;
  logic [31:0] old_w;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] wr_dat;
  logic [5:0]  rd_base;
  logic [127:0] rd_key;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    case (bus.key_size)
      2'd0:    req_nk = 4'd4;
      2'd1:    req_nk = 4'd6;
      2'd2:    req_nk = 4'd8;
      default: req_nk = 4'd0;
    endcase
    req_legal = (bus.key_size != 2'd3) && (req_nk <= MAX_NK_L);
    req_nr    = req_nk + 4'd6;
  end

  always_comb begin
    prev_w  = w_q[i_q - 6'd1];
    old_w   = w_q[i_q - {2'b00, nk_q}];
    sub_in  = (j_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = sub_word(sub_in);
    if (j_q == 4'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 4'd4)
      temp = sub_out;
    else
      temp = prev_w;
    wr_dat = old_w ^ temp;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    nk_d    = nk_q;
    rcon_d  = rcon_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = kv_q;
    nr_d    = nr_q;
    load_en = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (req_legal) begin
            load_en = 1'b1;
            nk_d    = req_nk;
            i_d     = {2'b00, req_nk};
            j_d     = 4'd0;
            rcon_d  = 8'h01;
            last_d  = {req_nr, 2'b11};
            kv_d    = 1'b0;
            state_d = S_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXPAND: begin
        wr_en = 1'b1;
        i_d   = i_q + 6'd1;
        j_d   = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
        if (j_q == 4'd0) rcon_d = xt(rcon_q);
        if (i_q == last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          nr_d    = nk_q + 4'd6;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      nk_q    <= '0;
      rcon_q  <= 8'h01;
      last_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
      nr_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      nk_q    <= nk_d;
      rcon_q  <= rcon_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
      nr_q    <= nr_d;
    end
  end

  // Store has no reset: key_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (4'(k) < req_nk) w_q[k] <= bus.key[32*k +: 32];
      end
    end else if (wr_en) begin
      w_q[i_q] <= wr_dat;
    end
  end

  always_comb begin
    rd_base = {bus.rd_round, 2'b00};
    rd_key  = '0;
    if (kv_q && (bus.rd_round <= nr_q))
      rd_key = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
  end

  assign bus.busy      = (state_q == S_EXPAND);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.key_valid = kv_q;
  assign bus.nr        = nr_q;
  assign bus.rd_key    = rd_key;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq: FIPS-197 schedules, latency, error and reset cases.
module tb_key_expansion_seq;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  key_expansion_seq_if #(.MAX_NK(8)) bus ();
  key_expansion_seq_if #(.MAX_NK(4)) bus4 ();

  key_expansion_seq #(.MAX_NK(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  key_expansion_seq #(.MAX_NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Drives one start and returns cycles from the start edge to done (-1 if it never comes).
  task automatic run_expand(input logic [255:0] k, input logic [1:0] ks, output int lat);
    @(negedge clk);
    bus.key      = k;
    bus.key_size = ks;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.key_valid, bus.nr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {bus.busy, bus.done, bus.err, bus.key_valid, bus.nr});
    end
    checks++;
    if (bus.rd_key !== 128'h0) begin
      errors++;
      $display("FAIL reset_rd_key: got %h expected 0", bus.rd_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.key_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got busy/kv %b expected 00", {bus.busy, bus.key_valid});
    end
  endtask

  task automatic test_aes128();
    int lat;
    run_expand(K128, 2'd0, lat);
    checks++;
    if (lat !== 40) begin errors++; $display("FAIL aes128_latency: got %0d expected 40", lat); end
    checks++;
    if ({bus.busy, bus.key_valid, bus.nr} !== {2'b01, 4'd10}) begin
      errors++;
      $display("FAIL aes128_status: got busy %b kv %b nr %0d expected 0 1 10", bus.busy, bus.key_valid, bus.nr);
    end
    bus.rd_round = 4'd0; #1;
    checks++;
    if (bus.rd_key !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++; $display("FAIL aes128_round0: got %h expected 2b7e151628aed2a6abf7158809cf4f3c", bus.rd_key);
    end
    bus.rd_round = 4'd1; #1;
    checks++;
    if (bus.rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++; $display("FAIL aes128_round1: got %h expected a0fafe1788542cb123a339392a6c7605", bus.rd_key);
    end
    bus.rd_round = 4'd10; #1;
    checks++;
    if (bus.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL aes128_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus.rd_key);
    end
  endtask

  task automatic test_invalid_size();
    int lat;
    @(negedge clk);
    bus.key_size = 2'd3;
    bus.key      = K256;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.err, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL illegal_err_pulse: got err/busy %b expected 10", {bus.err, bus.busy});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.err, bus.key_valid} !== 2'b01) begin
      errors++; $display("FAIL illegal_err_clear: got err/kv %b expected 01", {bus.err, bus.key_valid});
    end
    bus.rd_round = 4'd10; #1;
    checks++;
    if (bus.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL illegal_keeps_schedule: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus.rd_key);
    end
    // AES-256 request on an instance limited to 128-bit keys
    @(negedge clk);
    bus4.key_size = 2'd2;
    bus4.start    = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    checks++;
    if ({bus4.err, bus4.busy} !== 2'b10) begin
      errors++; $display("FAIL small_nk_err: got err/busy %b expected 10", {bus4.err, bus4.busy});
    end
    @(negedge clk);
    bus4.key      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus4.key_size = 2'd0;
    bus4.start    = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (bus4.done) begin lat = c; break; end
    end
    checks++;
    if (lat !== 40) begin errors++; $display("FAIL small_aes128_latency: got %0d expected 40", lat); end
    bus4.rd_round = 4'd10; #1;
    checks++;
    if (bus4.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL small_aes128_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus4.rd_key);
    end
  endtask

  task automatic test_start_while_busy();
    int   lat;
    logic saw_err;
    @(negedge clk);
    bus.key      = K128;
    bus.key_size = 2'd0;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    saw_err = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 10) begin
        bus.key      = K256;
        bus.key_size = 2'd2;
        bus.start    = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.err) saw_err = 1'b1;
      if (bus.done) begin lat = c; break; end
    end
    checks++;
    if (lat !== 40 || saw_err !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored: got latency %0d err %b expected 40 0", lat, saw_err);
    end
    bus.rd_round = 4'd10; #1;
    checks++;
    if (bus.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL busy_start_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus.rd_key);
    end
    bus.rd_round = 4'd11; #1;
    checks++;
    if (bus.rd_key !== 128'h0) begin
      errors++; $display("FAIL round_above_nr: got %h expected 0", bus.rd_key);
    end
  endtask

  // Each new start lands in the cycle where the previous done is still high.
  task automatic test_back_to_back();
    int lat;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done_high: got %b expected 1", bus.done); end
    run_expand(K192, 2'd1, lat);
    checks++;
    if (lat !== 46) begin errors++; $display("FAIL aes192_latency: got %0d expected 46", lat); end
    checks++;
    if (bus.nr !== 4'd12) begin errors++; $display("FAIL aes192_nr: got %0d expected 12", bus.nr); end
    bus.rd_round = 4'd12; #1;
    checks++;
    if (bus.rd_key !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++; $display("FAIL aes192_round12: got %h expected e98ba06f448c773c8ecc720401002202", bus.rd_key);
    end
    bus.rd_round = 4'd1; #1;
    checks++;
    if (bus.rd_key[63:32] !== 32'hfe0c91f7) begin
      errors++; $display("FAIL aes192_w6: got %h expected fe0c91f7", bus.rd_key[63:32]);
    end
    run_expand(K256, 2'd2, lat);
    checks++;
    if (lat !== 52) begin errors++; $display("FAIL aes256_latency: got %0d expected 52", lat); end
    checks++;
    if (bus.nr !== 4'd14) begin errors++; $display("FAIL aes256_nr: got %0d expected 14", bus.nr); end
    bus.rd_round = 4'd2; #1;
    checks++;
    if (bus.rd_key[127:96] !== 32'h9ba35411) begin
      errors++; $display("FAIL aes256_w8: got %h expected 9ba35411", bus.rd_key[127:96]);
    end
    bus.rd_round = 4'd3; #1;
    checks++;
    if (bus.rd_key[127:96] !== 32'ha8b09c1a) begin
      errors++; $display("FAIL aes256_w12: got %h expected a8b09c1a", bus.rd_key[127:96]);
    end
    bus.rd_round = 4'd14; #1;
    checks++;
    if (bus.rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      errors++; $display("FAIL aes256_round14: got %h expected fe4890d1e6188d0b046df344706c631e", bus.rd_key);
    end
    bus.rd_round = 4'd15; #1;
    checks++;
    if (bus.rd_key !== 128'h0) begin
      errors++; $display("FAIL aes256_round15: got %h expected 0", bus.rd_key);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.key      = K256;
    bus.key_size = 2'd2;
    bus.start    = 1'b1;
    bus.rd_round = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.key_valid, bus.done} !== 3'b000 || bus.rd_key !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset_abort: got busy/kv/done %b rd_key %h expected 000 and 0",
               {bus.busy, bus.key_valid, bus.done}, bus.rd_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_expand(K128, 2'd0, lat);
    checks++;
    if (lat !== 40) begin errors++; $display("FAIL restart_latency: got %0d expected 40", lat); end
    bus.rd_round = 4'd10; #1;
    checks++;
    if (bus.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL restart_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus.rd_key);
    end
  endtask

  initial begin
    bus.key       = '0;
    bus.key_size  = 2'd0;
    bus.start     = 1'b0;
    bus.rd_round  = 4'd0;
    bus4.key      = '0;
    bus4.key_size = 2'd0;
    bus4.start    = 1'b0;
    bus4.rd_round = 4'd0;
    test_reset();
    test_aes128();
    test_invalid_size();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Sequential, run-time-selectable AES key scheduler supporting AES-128, AES-192 and AES-256 (FIPS-197 KeyExpansion).
- Generates one 32-bit schedule word per clock into an internal word store.
- Exposes any round key through a combinational read port.
- Sits between key load logic and the round datapath; replaces fully combinational, fixed-size expansion with a small iterative core (one SubWord unit).

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8). Sizes the key port and the store (4*(MAX_NK+7) words). key_size requests above MAX_NK are rejected.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- key  input  32*MAX_NK  cipher key, bit 0 = MSB of w[0]; AES-128 uses key[0:127], AES-192 uses key[0:191]
- key_size  input  2  0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = illegal
- start  input  1  single-cycle request; sampled only when busy=0
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse when the last word is written
- err  output  1  one-cycle pulse: start rejected (illegal key_size, or Nk > MAX_NK)
- key_valid  output  1  store holds a complete schedule
- nr  output  4  round count of the stored schedule (10/12/14)
- rd_round  input  4  round-key index to read
- rd_key  output  128  words w[4r]..w[4r+3] concatenated, w[4r] in MSBs

Behaviour:
- Reset (async assert; release synchronised to clk):
  - busy, done, err, key_valid = 0; nr = 0; rd_key = 0.
  - Store contents are don't-care.
- States: IDLE, EXPAND.
- IDLE, start=1:
  - Legal key_size: on that edge write w[0..Nk-1] from key, latch Nk and Nr=Nk+6, set i=Nk, j=0 (i mod Nk counter), rcon=8'h01, key_valid=0, busy=1, then enter EXPAND.
  - Illegal key_size: err pulses the next cycle; state, store and key_valid are unchanged.
- EXPAND, each edge:
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp; i++; j wraps at Nk-1 -> 0.
- Termination:
  - After the edge writing w[4*Nr+3] (index 43/51/59): busy=0, done=1 for one cycle, key_valid=1, nr=Nr, return to IDLE.
  - Latency from the start-sampling edge to the done-rising edge: 40/46/52 cycles (AES-128/192/256).
- SubWord: four combinational S-box lookups; a single SubWord unit is shared. No division: j and rcon are maintained incrementally.
- Read port:
  - Purely combinational from the store.
  - rd_key = 0 when key_valid=0 or rd_round > nr.
- start while busy=1: ignored, no err.
- Reset mid-expansion: immediate abort, key_valid=0; a fresh start is required.
- done and start in the same cycle: start is accepted (busy=0 that cycle).

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done exactly 40 cycles after the start edge; rd_round=1 gives a0fafe1788542cb123a339392a6c7605; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; nr=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at 46 cycles; rd_round=12 gives e98ba06f448c773c8ecc720401002202; w[6]=fe0c91f7.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at 52 cycles; w[8]=9ba35411 and w[12] confirm the j==4 SubWord path; rd_round=14 gives fe4890d1e6188d0b046df344706c631e.
- key_size=3 with start -> err pulses for 1 cycle, busy stays 0, prior key_valid and schedule are preserved; with MAX_NK=4, key_size=2 -> err pulses likewise.
- Pulse start again at cycle 10 of a busy expansion -> ignored, result identical to the first test; rd_round=11 after an AES-128 run -> rd_key=0.
- Assert rst_n=0 at cycle 20 of an AES-256 run -> busy/key_valid drop immediately and rd_key=0; restart with the AES-128 key -> correct schedule and 40-cycle latency.
